// File: rtl/sys_msg_injector.sv
// Purpose : Host-loadable FIX message buffer (Avalon-MM slave) streamed out as a valid/ready byte source.
// Latency : register reads return one cycle after slave_read; the first byte is valid two cycles after SEND.
// Backpr. : tx_data/tx_last hold while tx_valid && !tx_ready; one byte per clock while tx_ready stays high.
//
// Ports:
//   clk, reset                          single clock, synchronous active-high reset
//   slave_address/read/readdata         register select, read strobe, read data (latency 1)
//   slave_write/writedata               write strobe and data
//   tx_data/tx_valid/tx_last/tx_ready   byte stream toward the FIX engine
//   tx_sel                              0 = initiator input, 1 = acceptor input (latched at SEND)
//
// Register map: 0 CTRL (W: b0 SEND, b1 CLEAR, b2 target; R: {3'b0,ovf,err,done,busy,full}),
//               1 DATA (W: append byte), 2 LEN (R), 3 CKSUM (R), 4 SENT (R).
module sys_msg_injector #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] slave_address,
    input  logic       slave_read,
    output logic [7:0] slave_readdata,
    input  logic       slave_write,
    input  logic [7:0] slave_writedata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_last,
    input  logic       tx_ready,
    output logic       tx_sel
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CAP = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] len_q,    len_d;
    logic [ADDR_WIDTH-1:0] sent_q,   sent_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]            cksum_q,  cksum_d;
    logic                  done_q,   done_d;
    logic                  err_q,    err_d;
    logic                  ovf_q,    ovf_d;
    logic                  tx_sel_q, tx_sel_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_last_q,  tx_last_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic [7:0]            rdata_q,    rdata_d;

    logic busy, full, ctrl_wr, data_wr, do_clear, do_send, accept, mem_we;

    always_comb begin
        busy     = (state_q == S_FETCH) || (state_q == S_SEND);
        full     = (len_q == CAP);
        ctrl_wr  = slave_write && (slave_address == 3'd0);
        data_wr  = slave_write && (slave_address == 3'd1);
        do_clear = ctrl_wr && slave_writedata[1];
        // CLEAR wins over SEND in the same write.
        do_send  = ctrl_wr && slave_writedata[0] && !slave_writedata[1];
        accept   = tx_valid_q && tx_ready;
        mem_we   = data_wr && !busy && !full;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sent_d     = sent_q;
        rd_ptr_d   = rd_ptr_q;
        cksum_d    = cksum_q;
        done_d     = done_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        tx_sel_d   = tx_sel_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        tx_data_d  = tx_data_q;
        rdata_d    = 8'h00;

        // Read mux works on current state, so a simultaneous write is not yet visible.
        if (slave_read) begin
            case (slave_address)
                3'd0:    rdata_d = {3'b000, ovf_q, err_q, done_q, busy, full};
                3'd2:    rdata_d = 8'(len_q);
                3'd3:    rdata_d = cksum_q;
                3'd4:    rdata_d = 8'(sent_q);
                default: rdata_d = 8'h00;
            endcase
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (data_wr) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        len_d   = len_q + ONE;
                        cksum_d = cksum_q + slave_writedata;
                    end
                end
                if (do_send) begin
                    if (len_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = S_FETCH;
                        sent_d   = '0;
                        done_d   = 1'b0;
                        rd_ptr_d = '0;
                        tx_sel_d = slave_writedata[2];
                    end
                end
            end
            S_FETCH: begin
                // First byte read out of the buffer; the stream goes valid next cycle.
                tx_data_d  = mem[rd_ptr_q];
                tx_valid_d = 1'b1;
                tx_last_d  = (rd_ptr_q == len_q - ONE);
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (accept) begin
                    sent_d = sent_q + ONE;
                    if (tx_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        // Prefetch the following byte so the stream has no bubble.
                        rd_ptr_d  = rd_ptr_q + ONE;
                        tx_data_d = mem[rd_ptr_q + ONE];
                        tx_last_d = ((rd_ptr_q + ONE) == (len_q - ONE));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Loading or re-sending while the buffer is being streamed is a host error.
        if (busy && (data_wr || do_send)) begin
            err_d = 1'b1;
        end

        // CLEAR aborts everything, including a stream in flight.
        if (do_clear) begin
            state_d    = S_IDLE;
            len_d      = '0;
            sent_d     = '0;
            rd_ptr_d   = '0;
            cksum_d    = 8'h00;
            done_d     = 1'b0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            sent_q     <= '0;
            rd_ptr_q   <= '0;
            cksum_q    <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tx_sel_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            rd_ptr_q   <= rd_ptr_d;
            cksum_q    <= cksum_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            tx_sel_q   <= tx_sel_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_data_q  <= tx_data_d;
            rdata_q    <= rdata_d;
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_q] <= slave_writedata;
        end
    end

    assign slave_readdata = rdata_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign tx_last        = tx_last_q;
    assign tx_sel         = tx_sel_q;

endmodule

// File: tb/tb_sys_msg_injector.sv
module tb_sys_msg_injector;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] slave_address;
    logic       slave_read;
    logic [7:0] slave_readdata;
    logic       slave_write;
    logic [7:0] slave_writedata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_sel;

    sys_msg_injector #(.ADDR_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_address   (slave_address),
        .slave_read      (slave_read),
        .slave_readdata  (slave_readdata),
        .slave_write     (slave_write),
        .slave_writedata (slave_writedata),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_last         (tx_last),
        .tx_ready        (tx_ready),
        .tx_sel          (tx_sel)
    );

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];      // {last, data} of every byte the engine should accept
    logic       exp_sel = 1'b0;
    logic [7:0] v;
    logic [7:0] sum;
    logic [7:0] b;
    logic [7:0] fix_msg [0:8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        tick();
        slave_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        tick();
        d             = slave_readdata;
        slave_read    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    // Poll CTRL.done with a cycle budget; optionally randomise tx_ready while waiting.
    task automatic wait_done(input string tag, input int budget, input bit rnd);
        logic [7:0] d;
        bit         ok;
        ok = 1'b0;
        repeat (budget) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            rd(3'd0, d);
            if (d[2]) begin
                ok = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        check(tag, 32'(ok), 32'd1);
    endtask

    // Scoreboard: every handshake must match the next expected byte.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected_byte", 32'(tx_data), 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data), 32'(e[7:0]));
                check("tx_last", 32'(tx_last), 32'(e[8]));
                check("tx_sel",  32'(tx_sel),  32'(exp_sel));
            end
        end
    end

    initial begin
        fix_msg = '{8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h2E, 8'h34, 8'h2E, 8'h32};
        reset = 1'b1; slave_address = 3'd0; slave_read = 1'b0; slave_write = 1'b0;
        slave_writedata = 8'h00; tx_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_last",  32'(tx_last),  32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_tx_sel",   32'(tx_sel),   32'd0);
        reset = 1'b0;
        tick();
        rd_chk("rst_ctrl", 3'd0, 8'h00);
        rd_chk("rst_len",  3'd2, 8'h00);
        rd_chk("rst_sent", 3'd4, 8'h00);
        rd_chk("unmapped_rd", 3'd6, 8'h00);

        // 1: load "8=FIX.4.2", check LEN and FIX checksum
        sum = 8'h00;
        for (int i = 0; i < 9; i++) begin
            wr(3'd1, fix_msg[i]);
            sum = sum + fix_msg[i];
        end
        rd_chk("t1_len",   3'd2, 8'd9);
        rd_chk("t1_cksum", 3'd3, sum);
        wr(3'd7, 8'hFF);   // ignored
        rd_chk("t1_len_after_unmapped_wr", 3'd2, 8'd9);
        wr(3'd0, 8'h02);

        // 2: four bytes back to back, initiator target
        for (int i = 1; i <= 4; i++) begin
            wr(3'd1, 8'(i));
            exp_q.push_back({(i == 4), 8'(i)});
        end
        tx_ready = 1'b1;
        exp_sel  = 1'b0;
        wr(3'd0, 8'h01);
        check("t2_fetch_not_valid", 32'(tx_valid), 32'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            check("t2_b2b_valid", 32'(tx_valid), 32'd1);
            check("t2_b2b_data",  32'(tx_data),  32'(i));
            tick();
        end
        check("t2_valid_drop", 32'(tx_valid), 32'd0);
        rd_chk("t2_ctrl_done", 3'd0, 8'h04);
        rd_chk("t2_sent",      3'd4, 8'd4);

        // 3: stall on byte 2 for three cycles, acceptor target
        wr(3'd0, 8'h02);
        for (int i = 1; i <= 4; i++) begin
            wr(3'd1, 8'(i * 17));
            exp_q.push_back({(i == 4), 8'(i * 17)});
        end
        tx_ready = 1'b0;
        exp_sel  = 1'b1;
        wr(3'd0, 8'h05);
        tick();
        check("t3_first_data", 32'(tx_data), 32'h11);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        repeat (3) begin
            tick();
            check("t3_hold_valid", 32'(tx_valid), 32'd1);
            check("t3_hold_data",  32'(tx_data),  32'h22);
            check("t3_hold_last",  32'(tx_last),  32'd0);
        end
        tx_ready = 1'b1;
        wait_done("t3_done_timeout", 50, 1'b0);
        rd_chk("t3_sent", 3'd4, 8'd4);
        check("t3_tx_sel", 32'(tx_sel), 32'd1);

        // 4: overflow at capacity, stream all 255 bytes under random backpressure
        wr(3'd0, 8'h02);
        sum     = 8'h00;
        exp_sel = 1'b0;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i * 7 + 3);
            wr(3'd1, b);
            if (i < 255) begin
                exp_q.push_back({(i == 254), b});
                sum = sum + b;
            end
        end
        rd_chk("t4_len",      3'd2, 8'hFF);
        rd_chk("t4_full_ovf", 3'd0, 8'h11);
        rd_chk("t4_cksum",    3'd3, sum);
        wr(3'd0, 8'h01);
        wait_done("t4_done_timeout", 3000, 1'b1);
        rd_chk("t4_sent",      3'd4, 8'hFF);
        rd_chk("t4_ctrl_done", 3'd0, 8'h15);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: SEND with empty buffer, read/write collision, CLEAR mid-stream
        wr(3'd0, 8'h02);
        wr(3'd0, 8'h01);
        tick();
        check("t5_empty_no_valid", 32'(tx_valid), 32'd0);
        rd_chk("t5_err", 3'd0, 8'h08);
        slave_address = 3'd0; slave_writedata = 8'h02;
        slave_read = 1'b1; slave_write = 1'b1;
        tick();
        slave_read = 1'b0; slave_write = 1'b0;
        check("t5_rd_pre_write", 32'(slave_readdata), 32'h08);
        rd_chk("t5_ctrl_cleared", 3'd0, 8'h00);
        for (int i = 0; i < 5; i++) wr(3'd1, 8'(8'hA1 + i));
        exp_q.push_back({1'b0, 8'hA1});
        exp_q.push_back({1'b0, 8'hA2});
        tx_ready = 1'b1;
        wr(3'd0, 8'h01);
        repeat (3) tick();
        tx_ready = 1'b0;
        check("t5_pre_clear_data", 32'(tx_data), 32'hA3);
        wr(3'd0, 8'h02);
        check("t5_clear_valid", 32'(tx_valid), 32'd0);
        rd_chk("t5_clear_len",  3'd2, 8'h00);
        rd_chk("t5_clear_ctrl", 3'd0, 8'h00);
        rd_chk("t5_clear_sent", 3'd4, 8'h00);

        // 6: DATA write and SEND while streaming, then reset mid-stream
        for (int i = 0; i < 3; i++) wr(3'd1, 8'(8'h60 + i));
        tx_ready = 1'b0;
        wr(3'd0, 8'h05);
        tick();
        wr(3'd1, 8'h77);
        rd_chk("t6_busy_err", 3'd0, 8'h0A);
        rd_chk("t6_len_kept", 3'd2, 8'd3);
        check("t6_valid_busy", 32'(tx_valid), 32'd1);
        check("t6_sel_busy",   32'(tx_sel),   32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_last",  32'(tx_last),  32'd0);
        check("t6_rst_data",  32'(tx_data),  32'd0);
        check("t6_rst_sel",   32'(tx_sel),   32'd0);
        reset = 1'b0;
        rd_chk("t6_rst_len",  3'd2, 8'h00);
        rd_chk("t6_rst_ctrl", 3'd0, 8'h00);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
